divider_n: RTL and testbench

//  Parametrised multi-cycle integer divider for the RISC5 execute stage; successor to the fixed 32-bit

---
 rtl/divider_n.sv | 148 ++++++++++++++
 tb/tb_divider_n.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/divider_n.sv
// divider_n: multi-cycle restoring integer divider for the execute stage.
// Unsigned or signed (floor) division, WIDTH-bit operands, BPC quotient bits
// per enabled cycle, run/stall handshake shared with the multiplier.
// Optional feature macro: DIVIDER_DZ_EN adds divide-by-zero detection and the
// dz flag; when undefined dz is tied low and no zero detection exists.
module divider_n #(
   parameter int WIDTH = 32,
   parameter int BPC   = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             run,
   input  logic             u,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   output logic             stall,
   output logic [WIDTH-1:0] quot,
   output logic [WIDTH-1:0] rem,
   output logic             dz
);

   localparam int N  = WIDTH / BPC;
   localparam int SW = $clog2(N + 2);
   localparam logic [SW-1:0] S_DONE = SW'(N + 1);

   logic [SW-1:0]        s_q, s_d;
   logic [2*WIDTH-1:0]   rq_q, rq_d, rq_step;
   logic [WIDTH-1:0]     yd_q, yd_d;
   logic                 sx_q, sx_d, sy_q, sy_d;
`ifdef DIVIDER_DZ_EN
   logic                 dz_q, dz_d;
`endif

   logic                 xneg, yneg;
   logic [WIDTH-1:0]     ax, ay;
   logic [WIDTH-1:0]     q0, r0, rp;
   logic                 ne, r_nz;

   // Operand magnitudes; only signed mode folds negative operands.
   assign xneg = u & x[WIDTH-1];
   assign yneg = u & y[WIDTH-1];
   assign ax   = xneg ? -x : x;
   assign ay   = yneg ? -y : y;

   // BPC restoring steps per cycle. The trial subtraction includes the bit
   // shifted out of the top of RQ, so unsigned divisors above 2^(WIDTH-1)
   // still compare correctly; for smaller divisors that bit is always zero.
   always_comb begin : step_blk
      logic [WIDTH:0] w_ext;
      logic [WIDTH:0] diff;
      rq_step = rq_q;
      w_ext   = '0;
      diff    = '0;
      for (int i = 0; i < BPC; i++) begin
         w_ext = rq_step[2*WIDTH-1:WIDTH-1];
         diff  = w_ext - {1'b0, yd_q};
         if (!diff[WIDTH]) begin
            rq_step = {diff[WIDTH-1:0], rq_step[WIDTH-2:0], 1'b1};
         end else begin
            rq_step = {w_ext[WIDTH-1:0], rq_step[WIDTH-2:0], 1'b0};
         end
      end
   end

   // Step counter and datapath next state: load at S==0, iterate to N, hold at N+1.
   always_comb begin
      s_d  = s_q;
      rq_d = rq_q;
      yd_d = yd_q;
      sx_d = sx_q;
      sy_d = sy_q;
`ifdef DIVIDER_DZ_EN
      dz_d = dz_q;
`endif
      if (!run) begin
         s_d = '0;
      end else if (s_q == '0) begin
         s_d  = SW'(1);
         rq_d = {{WIDTH{1'b0}}, ax};
         yd_d = ay;
         sx_d = xneg;
         sy_d = yneg;
`ifdef DIVIDER_DZ_EN
         dz_d = 1'b0;
         if (ay == '0) begin
            // Zero divisor: finish at once, keeping raw x for the remainder.
            dz_d = 1'b1;
            s_d  = S_DONE;
            rq_d = {x, {WIDTH{1'b1}}};
         end
`endif
      end else if (s_q != S_DONE) begin
         s_d  = s_q + SW'(1);
         rq_d = rq_step;
      end
   end

   // State registers: reset wins over enable, enable low freezes everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         s_q  <= '0;
         rq_q <= '0;
         yd_q <= '0;
         sx_q <= 1'b0;
         sy_q <= 1'b0;
`ifdef DIVIDER_DZ_EN
         dz_q <= 1'b0;
`endif
      end else if (enable) begin
         s_q  <= s_d;
         rq_q <= rq_d;
         yd_q <= yd_d;
         sx_q <= sx_d;
         sy_q <= sy_d;
`ifdef DIVIDER_DZ_EN
         dz_q <= dz_d;
`endif
      end
   end

   assign stall = run & (s_q != S_DONE);

   assign q0   = rq_q[WIDTH-1:0];
   assign r0   = rq_q[2*WIDTH-1:WIDTH];
   assign ne   = sx_q ^ sy_q;
   assign r_nz = |r0;
   assign rp   = (ne & r_nz) ? (yd_q - r0) : r0;

   // Floor correction: quotient rounds toward -inf, remainder takes divisor sign.
   always_comb begin
      quot = ne ? -(q0 + {{(WIDTH-1){1'b0}}, r_nz}) : q0;
      rem  = sy_q ? -rp : rp;
`ifdef DIVIDER_DZ_EN
      if (dz_q) begin
         quot = {WIDTH{1'b1}};
         rem  = r0;
      end
`endif
   end

`ifdef DIVIDER_DZ_EN
   assign dz = dz_q;
`else
   assign dz = 1'b0;
`endif

endmodule

// File: tb/tb_divider_n.sv
// tb_divider_n: table-driven bench for divider_n with a scoreboard queue.
// Two instances: BPC=1 (sel 0) and BPC=4 (sel 1), both WIDTH=32.
// Build with DIVIDER_DZ_EN defined to include the divide-by-zero vectors.
module tb_divider_n;

   logic        clk = 1'b0;
   logic        rst, enable, u, run1, run4;
   logic [31:0] x, y;
   logic        stall1, stall4, dz1, dz4;
   logic [31:0] quot1, rem1, quot4, rem4;

   always #5 clk = ~clk;

   divider_n #(.WIDTH(32), .BPC(1)) dut1 (
      .clk(clk), .rst(rst), .enable(enable), .run(run1), .u(u), .x(x), .y(y),
      .stall(stall1), .quot(quot1), .rem(rem1), .dz(dz1));

   divider_n #(.WIDTH(32), .BPC(4)) dut4 (
      .clk(clk), .rst(rst), .enable(enable), .run(run4), .u(u), .x(x), .y(y),
      .stall(stall4), .quot(quot4), .rem(rem4), .dz(dz4));

   typedef struct {
      int          sel;
      logic        uu;
      logic [31:0] xx;
      logic [31:0] yy;
      logic [31:0] q;
      logic [31:0] r;
      logic        dzv;
      int          len;
   } vec_t;

   vec_t tbl[$];
   vec_t exp_q[$];
   int   errors = 0;
   int   checks = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, expv);
      end
   endtask

   // Independent floor-division reference using 64-bit arithmetic.
   function automatic void model(input logic uu, input logic [31:0] xx, input logic [31:0] yy,
                                 output logic [31:0] q, output logic [31:0] r);
      longint a, b, qq, rr;
      if (uu) begin
         a = longint'($signed(xx));
         b = longint'($signed(yy));
      end else begin
         a = {32'b0, xx};
         b = {32'b0, yy};
      end
      qq = a / b;
      rr = a - qq * b;
      if (rr != 0 && ((rr < 0) != (b < 0))) begin
         qq = qq - 1;
         rr = rr + b;
      end
      q = qq[31:0];
      r = rr[31:0];
   endfunction

   // Drive one division, count stall cycles, scramble operands after the load,
   // optionally drop enable for 5 cycles, then pop and compare the expectation.
   task automatic run_op(input vec_t v, input int hold_at, input string nm);
      vec_t        e;
      int          cnt;
      logic        timeout;
      logic [31:0] qa, ra;
      logic        da;
      exp_q.push_back(v);
      @(negedge clk);
      u = v.uu; x = v.xx; y = v.yy;
      if (v.sel == 0) run1 = 1'b1; else run4 = 1'b1;
      cnt = 0;
      timeout = 1'b0;
      #1;
      while (((v.sel == 0) ? stall1 : stall4) && !timeout) begin
         cnt++;
         if (hold_at > 0 && cnt == hold_at)     enable = 1'b0;
         if (hold_at > 0 && cnt == hold_at + 5) enable = 1'b1;
         if (cnt > 200) timeout = 1'b1;
         @(negedge clk);
         #1;
         x = $urandom;
         y = $urandom;
      end
      enable = 1'b1;
      if (timeout) begin
         errors++;
         $display("FAIL %s_timeout: stall still high after %0d cycles", nm, cnt);
      end
      e  = exp_q.pop_front();
      qa = (v.sel == 0) ? quot1 : quot4;
      ra = (v.sel == 0) ? rem1  : rem4;
      da = (v.sel == 0) ? dz1   : dz4;
      chk({nm, "_len"},  cnt, e.len);
      chk({nm, "_quot"}, qa, e.q);
      chk({nm, "_rem"},  ra, e.r);
      chk({nm, "_dz"},   {31'b0, da}, {31'b0, e.dzv});
      run1 = 1'b0;
      run4 = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        v;
      logic [31:0] mq, mr;

      tbl.push_back('{0, 1'b0, 32'd100,        32'd7,         32'd14,        32'd2,         1'b0, 33});
      tbl.push_back('{0, 1'b1, -32'd7,         32'd2,         -32'd4,        32'd1,         1'b0, 33});
      tbl.push_back('{0, 1'b1, 32'd7,          -32'd2,        -32'd4,        -32'd1,        1'b0, 33});
      tbl.push_back('{0, 1'b1, -32'd7,         -32'd2,        32'd3,         -32'd1,        1'b0, 33});
      tbl.push_back('{0, 1'b1, -32'd8,         32'd2,         -32'd4,        32'd0,         1'b0, 33});
      tbl.push_back('{0, 1'b1, 32'h80000000,   32'hFFFFFFFF,  32'h80000000,  32'd0,         1'b0, 33});
      tbl.push_back('{0, 1'b0, 32'hFFFFFFFF,   32'd1,         32'hFFFFFFFF,  32'd0,         1'b0, 33});
      tbl.push_back('{0, 1'b1, 32'd5,          -32'd3,        -32'd2,        -32'd1,        1'b0, 33});
      tbl.push_back('{1, 1'b0, 32'd1000,       32'd3,         32'd333,       32'd1,         1'b0, 9});
      tbl.push_back('{1, 1'b1, -32'd1000,      32'd7,         -32'd143,      32'd1,         1'b0, 9});
      tbl.push_back('{1, 1'b0, 32'hFFFFFFFF,   32'hFFFFFFFE,  32'd1,         32'd1,         1'b0, 9});
`ifdef DIVIDER_DZ_EN
      tbl.push_back('{0, 1'b0, 32'd55,         32'd0,         32'hFFFFFFFF,  32'd55,        1'b1, 1});
      tbl.push_back('{0, 1'b0, 32'd55,         32'd5,         32'd11,        32'd0,         1'b0, 33});
      tbl.push_back('{1, 1'b1, -32'd9,         32'd0,         32'hFFFFFFFF,  -32'd9,        1'b1, 1});
      tbl.push_back('{1, 1'b1, -32'd9,         32'd4,         -32'd3,        32'd3,         1'b0, 9});
`endif

      // Reset state
      rst = 1'b1; enable = 1'b1; run1 = 1'b0; run4 = 1'b0; u = 1'b0; x = '0; y = '0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_quot1", quot1, 32'd0);
      chk("rst_rem1",  rem1,  32'd0);
      chk("rst_quot4", quot4, 32'd0);
      chk("rst_stall_idle", {31'b0, stall1}, 32'd0);
      chk("rst_dz", {31'b0, dz1}, 32'd0);
      run1 = 1'b1;
      #1;
      chk("rst_stall_run", {31'b0, stall1}, 32'd1);
      @(negedge clk);
      run1 = 1'b0;
      rst  = 1'b0;
      @(negedge clk);

      // Table vectors
      for (int i = 0; i < tbl.size(); i++) begin
         run_op(tbl[i], 0, $sformatf("vec%0d", i));
      end

      // Random vectors against the reference model
      for (int i = 0; i < 8; i++) begin
         v.sel = i % 2;
         v.uu  = $urandom_range(0, 1);
         v.xx  = $urandom;
         v.yy  = (i < 4) ? $urandom : 32'($urandom_range(1, 1000));
         if (i >= 4 && v.uu && $urandom_range(0, 1)) v.yy = -v.yy;
         if (v.yy == 0) v.yy = 32'd1;
         model(v.uu, v.xx, v.yy, mq, mr);
         v.q   = mq;
         v.r   = mr;
         v.dzv = 1'b0;
         v.len = (v.sel == 0) ? 33 : 9;
         run_op(v, 0, $sformatf("rnd%0d", i));
      end

      // Enable low for 5 cycles mid-divide stretches stall by 5
      run_op('{0, 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 38}, 10, "hold");

      // Abort: run low for one cycle, then a fresh load
      @(negedge clk);
      u = 1'b0; x = 32'd1000; y = 32'd3; run1 = 1'b1;
      repeat (10) @(negedge clk);
      run1 = 1'b0;
      run_op('{0, 1'b1, -32'd100, 32'd7, -32'd15, 32'd5, 1'b0, 33}, 0, "abort");

      // Reset mid-divide clears results; stall follows run
      @(negedge clk);
      u = 1'b0; x = 32'd100; y = 32'd7; run1 = 1'b1;
      repeat (10) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      #1;
      chk("midrst_quot",  quot1, 32'd0);
      chk("midrst_rem",   rem1,  32'd0);
      chk("midrst_stall", {31'b0, stall1}, 32'd1);
      rst = 1'b0;
      run1 = 1'b0;
      @(negedge clk);
      run_op('{0, 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33}, 0, "postrst");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
